sar_magnitude_search: RTL and testbench



---
 rtl/sar_magnitude_search.sv | 128 ++++++++++++
 tb/tb_sar_magnitude_search.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sar_magnitude_search.sv
// Successive-approximation search: drives a trial value into an external magnitude
// comparator and narrows MSB-first until equality or the last bit is resolved.
module sar_magnitude_search #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] steps,
  output logic             err
);

  localparam int unsigned KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_trial,  w_trial_nxt;
  logic [KW-1:0]    r_k,      w_k_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CNT_W-1:0] r_steps,  w_steps_nxt;
  logic             r_err,    w_err_nxt;
  logic             r_busy;
  logic             r_done;
  logic [KW-1:0]    w_k_dec;
  logic             w_onehot;

  assign w_k_dec  = r_k - KW'(1);
  assign w_onehot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                    ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                    ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

  // Next-state and datapath update for one compare per SEARCH cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_trial_nxt  = r_trial;
    w_k_nxt      = r_k;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_trial_nxt  = WIDTH'(1) << (WIDTH - 1);
          w_k_nxt      = KW'(WIDTH - 1);
          w_result_nxt = '0;
          w_steps_nxt  = '0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        w_steps_nxt = r_steps + CNT_W'(1);
        if (!w_onehot) begin
          w_err_nxt    = 1'b1;
          w_result_nxt = '0;
          w_state_nxt  = S_DONE;
        end else if (cmp_eq) begin
          w_result_nxt = r_trial;
          w_state_nxt  = S_DONE;
        end else if (cmp_lt) begin
          if (r_k != '0) begin
            w_trial_nxt[r_k]     = 1'b0;
            w_trial_nxt[w_k_dec] = 1'b1;
            w_k_nxt              = w_k_dec;
          end else begin
            w_result_nxt = {r_trial[WIDTH-1:1], 1'b0};
            w_state_nxt  = S_DONE;
          end
        end else begin
          // Unknown above trial at bit 0 contradicts the range invariant
          if (r_k != '0) begin
            w_trial_nxt[w_k_dec] = 1'b1;
            w_k_nxt              = w_k_dec;
          end else begin
            w_err_nxt    = 1'b1;
            w_result_nxt = '0;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_trial  <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trial  <= w_trial_nxt;
      r_k      <= w_k_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt == S_SEARCH);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign trial  = r_trial;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign steps  = r_steps;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// Bench for sar_magnitude_search: a behavioural comparator answers each trial, and an
// interval-halving reference model predicts trials, result, steps and err.
module tb_sar_magnitude_search;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  trial;
  logic          cmp_gt, cmp_lt, cmp_eq;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [CW-1:0] steps;

  int total = 0;
  int bad   = 0;
  int m_tr[16];

  sar_magnitude_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trial(trial),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .result(result), .steps(steps), .err(err)
  );

  always #5 clk = ~clk;

  // fk: 0 none, 1 gt+lt together, 2 all flags low, 3 gt only (fat==0 means every compare)
  typedef struct {
    int h; int fat; int fk; bit mid; bit poke;
    int xr; int xs; int xe;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Comparator response {gt,lt,eq} for compare number idx (1-based), with fault injection
  function automatic logic [2:0] flags(input int h, input int t, input int idx,
                                       input int fat, input int fk);
    logic [2:0] f;
    f = (h > t) ? 3'b100 : (h < t) ? 3'b010 : 3'b001;
    if (fk != 0 && (fat == idx || (fk == 3 && fat == 0))) begin
      case (fk)
        1:       f = 3'b110;
        2:       f = 3'b000;
        default: f = 3'b100;
      endcase
    end
    return f;
  endfunction

  // Interval model: unknown in [lo, lo+span); probe the midpoint until span collapses
  function automatic void model(input int h, input int fat, input int fk,
                                output int res, output int n, output int e);
    int lo, span, half, t;
    logic [2:0] f;
    lo = 0; span = 1 << W; n = 0; e = 0; res = 0;
    forever begin
      half = span / 2;
      t = lo + half;
      m_tr[n] = t;
      n++;
      f = flags(h, t, n, fat, fk);
      if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin e = 1; res = 0; break; end
      if (f[0]) begin res = t; break; end
      if (f[1]) begin
        if (half == 1) begin res = lo; break; end
        span = half;
      end else begin
        if (half == 1) begin e = 1; res = 0; break; end
        lo = t; span = half;
      end
    end
  endfunction

  task automatic run_search(input string tag, input int h, input int fat, input int fk,
                            input bit mid, input bit poke, input bit use_x,
                            input int xr, input int xs, input int xe);
    int mr, mn, me, cyc;
    logic [2:0] f;
    model(h, fat, fk, mr, mn, me);
    if (use_x) begin mr = xr; mn = xs; me = xe; end
    @(negedge clk);
    start = 1'b1;
    {cmp_gt, cmp_lt, cmp_eq} = 3'b000;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < W + 2) begin
      if (cyc < 16) chk({tag, ".trial"}, int'(trial), m_tr[cyc]);
      f = flags(h, int'(trial), cyc + 1, fat, fk);
      {cmp_gt, cmp_lt, cmp_eq} = f;
      start = (mid && cyc == 1);
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    {cmp_gt, cmp_lt, cmp_eq} = 3'b000;
    chk({tag, ".cycles"}, cyc, mn);
    chk({tag, ".done"},   int'(done), 1);
    chk({tag, ".result"}, int'(result), mr);
    chk({tag, ".steps"},  int'(steps), mn);
    chk({tag, ".err"},    int'(err), me);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_pulse"}, int'(done), 0);
    chk({tag, ".idle_busy"},  int'(busy), 0);
    chk({tag, ".held"},       int'(result), mr);
  endtask

  vec_t vecs[9];

  initial begin
    rst_n = 1'b0; start = 1'b0;
    {cmp_gt, cmp_lt, cmp_eq} = 3'b000;

    vecs[0] = '{h:11, fat:0, fk:0, mid:0, poke:1, xr:11, xs:4, xe:0};
    vecs[1] = '{h:8,  fat:0, fk:0, mid:0, poke:0, xr:8,  xs:1, xe:0};
    vecs[2] = '{h:15, fat:0, fk:0, mid:0, poke:0, xr:15, xs:4, xe:0};
    vecs[3] = '{h:0,  fat:0, fk:0, mid:0, poke:0, xr:0,  xs:4, xe:0};
    vecs[4] = '{h:1,  fat:0, fk:0, mid:0, poke:0, xr:1,  xs:4, xe:0};
    vecs[5] = '{h:11, fat:1, fk:1, mid:0, poke:0, xr:0,  xs:1, xe:1};
    vecs[6] = '{h:5,  fat:3, fk:2, mid:0, poke:0, xr:0,  xs:3, xe:1};
    vecs[7] = '{h:0,  fat:0, fk:3, mid:0, poke:0, xr:0,  xs:4, xe:1};
    vecs[8] = '{h:11, fat:0, fk:0, mid:1, poke:0, xr:11, xs:4, xe:0};

    repeat (2) @(negedge clk);
    chk("rst.trial", int'(trial), 0);
    chk("rst.busy",  int'(busy),  0);
    chk("rst.done",  int'(done),  0);
    chk("rst.steps", int'(steps), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_search($sformatf("vec%0d", i), vecs[i].h, vecs[i].fat, vecs[i].fk,
                 vecs[i].mid, vecs[i].poke, 1'b1, vecs[i].xr, vecs[i].xs, vecs[i].xe);

    // Asynchronous reset two compares into a search
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      {cmp_gt, cmp_lt, cmp_eq} = flags(11, int'(trial), c + 1, 0, 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.trial",  int'(trial),  0);
    chk("arst.busy",   int'(busy),   0);
    chk("arst.done",   int'(done),   0);
    chk("arst.result", int'(result), 0);
    chk("arst.steps",  int'(steps),  0);
    chk("arst.err",    int'(err),    0);
    {cmp_gt, cmp_lt, cmp_eq} = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    run_search("post_rst", 11, 0, 0, 1'b0, 1'b0, 1'b1, 11, 4, 0);

    for (int r = 0; r < 40; r++) begin
      int h, fat, fk;
      h   = int'($urandom_range(0, (1 << W) - 1));
      fk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fat = int'($urandom_range(0, W));
      run_search($sformatf("rnd%0d", r), h, fat, fk,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
